// File: rtl/dmem_arbiter.sv
// Single-port data RAM plus switch/display I/O slot shared by CPU and DBG ports.
// CPU has fixed priority; a wait counter forces a DBG grant after MAX_WAIT denials.
module dmem_arbiter #(
  parameter int AW       = 8,
  parameter int DW       = 8,
  parameter int IO_ADDR  = 255,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          sync_rst,
  input  logic          clk_en,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_stall,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_rvalid,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_gnt,
  output logic [DW-1:0] dbg_rdata,
  output logic          dbg_rvalid,
  input  logic [DW-1:0] switches,
  output logic [DW-1:0] disp
);
  localparam int             WCW   = $clog2(MAX_WAIT + 1);
  localparam int             DEPTH = 2**AW - 1;
  localparam logic [AW-1:0]  IO_A  = AW'(IO_ADDR);
  localparam logic [WCW-1:0] MAX_W = WCW'(MAX_WAIT);

  logic [DW-1:0]  ram_q [DEPTH];
  logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
  logic [DW-1:0]  disp_q, disp_d;
  logic [DW-1:0]  cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0]  dbg_rdata_q, dbg_rdata_d;
  logic           cpu_rvalid_q, cpu_rvalid_d;
  logic           dbg_rvalid_q, dbg_rvalid_d;

  logic           en, force_win, any_gnt, acc_we, acc_io, ram_we;
  logic           cpu_rd, dbg_rd;
  logic [AW-1:0]  acc_addr;
  logic [DW-1:0]  acc_wdata, rd_word;

  always_comb begin
    en        = clk_en & ~sync_rst;
    force_win = dbg_req & (wait_cnt_q == MAX_W);
    dbg_gnt   = en & dbg_req & (~cpu_req | force_win);
    cpu_gnt   = en & cpu_req & ~dbg_gnt;
    cpu_stall = cpu_req & ~cpu_gnt;
  end

  // Only one requester can hold the grant, so one shared access path suffices.
  always_comb begin
    any_gnt   = cpu_gnt | dbg_gnt;
    acc_addr  = dbg_gnt ? dbg_addr  : cpu_addr;
    acc_we    = dbg_gnt ? dbg_we    : cpu_we;
    acc_wdata = dbg_gnt ? dbg_wdata : cpu_wdata;
    acc_io    = (acc_addr == IO_A);
    rd_word   = acc_io ? switches : ram_q[acc_addr];
    ram_we    = any_gnt & acc_we & ~acc_io;
    cpu_rd    = cpu_gnt & ~cpu_we;
    dbg_rd    = dbg_gnt & ~dbg_we;
  end

  always_comb begin
    wait_cnt_d   = wait_cnt_q;
    disp_d       = disp_q;
    cpu_rdata_d  = cpu_rdata_q;
    dbg_rdata_d  = dbg_rdata_q;
    cpu_rvalid_d = cpu_rvalid_q;
    dbg_rvalid_d = dbg_rvalid_q;
    if (clk_en) begin
      cpu_rvalid_d = cpu_rd;
      dbg_rvalid_d = dbg_rd;
      if (cpu_rd) cpu_rdata_d = rd_word;
      if (dbg_rd) dbg_rdata_d = rd_word;
      if (any_gnt & acc_we & acc_io) disp_d = acc_wdata;
      if (~dbg_req | dbg_gnt) begin
        wait_cnt_d = '0;
      end else if (wait_cnt_q != MAX_W) begin
        wait_cnt_d = wait_cnt_q + WCW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      wait_cnt_q   <= '0;
      disp_q       <= '0;
      cpu_rdata_q  <= '0;
      dbg_rdata_q  <= '0;
      cpu_rvalid_q <= 1'b0;
      dbg_rvalid_q <= 1'b0;
    end else begin
      wait_cnt_q   <= wait_cnt_d;
      disp_q       <= disp_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dbg_rdata_q  <= dbg_rdata_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      dbg_rvalid_q <= dbg_rvalid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) ram_q[acc_addr] <= acc_wdata;
  end

  assign cpu_rdata  = cpu_rdata_q;
  assign dbg_rdata  = dbg_rdata_q;
  assign cpu_rvalid = cpu_rvalid_q;
  assign dbg_rvalid = dbg_rvalid_q;
  assign disp       = disp_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus randomized traffic against a behavioural model.
module tb_dmem_arbiter;
  localparam int MAXW = 4;
  localparam logic [7:0] IO = 8'd255;

  logic       clk = 1'b0;
  logic       sync_rst, clk_en;
  logic       cpu_req, cpu_we, dbg_req, dbg_we;
  logic [7:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata, switches;
  logic       cpu_gnt, cpu_stall, cpu_rvalid, dbg_gnt, dbg_rvalid;
  logic [7:0] cpu_rdata, dbg_rdata, disp;

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(8), .DW(8), .IO_ADDR(255), .MAX_WAIT(MAXW)) dut (
    .clk(clk), .sync_rst(sync_rst), .clk_en(clk_en),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rdata(dbg_rdata), .dbg_rvalid(dbg_rvalid),
    .switches(switches), .disp(disp)
  );

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model state
  logic [7:0] m_ram [256];
  bit         m_known [256];
  logic [7:0] m_disp, m_crd, m_drd;
  bit         m_crv, m_drv, m_crd_k, m_drd_k;
  int         m_denied;
  bit         e_cg, e_dg;

  function automatic void predict();
    bool_t_dummy: begin end
    e_dg = clk_en && !sync_rst && dbg_req && (!cpu_req || m_denied >= MAXW);
    e_cg = clk_en && !sync_rst && cpu_req && !e_dg;
  endfunction

  task automatic access(input logic we, input logic [7:0] a, input logic [7:0] wd,
                        inout logic [7:0] rd, inout bit rdk);
    if (we) begin
      if (a == IO) m_disp = wd;
      else begin m_ram[a] = wd; m_known[a] = 1'b1; end
    end else begin
      rd  = (a == IO) ? switches : m_ram[a];
      rdk = (a == IO) ? 1'b1 : m_known[a];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    predict();
    if (sync_rst) begin
      m_disp = 0; m_crd = 0; m_drd = 0; m_crv = 0; m_drv = 0;
      m_crd_k = 1; m_drd_k = 1; m_denied = 0;
    end else if (clk_en) begin
      m_crv = e_cg && !cpu_we;
      m_drv = e_dg && !dbg_we;
      if (e_cg) access(cpu_we, cpu_addr, cpu_wdata, m_crd, m_crd_k);
      if (e_dg) access(dbg_we, dbg_addr, dbg_wdata, m_drd, m_drd_k);
      if (dbg_req && !e_dg) m_denied = (m_denied < MAXW) ? m_denied + 1 : MAXW;
      else m_denied = 0;
    end
    #1;
  endtask

  task automatic drive_cpu(input logic req, input logic we, input logic [7:0] a, input logic [7:0] wd);
    cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
  endtask

  task automatic drive_dbg(input logic req, input logic we, input logic [7:0] a, input logic [7:0] wd);
    dbg_req = req; dbg_we = we; dbg_addr = a; dbg_wdata = wd;
  endtask

  // Grants must never collide
  always @(negedge clk) begin
    if (cpu_gnt === 1'b1 || dbg_gnt === 1'b1) begin
      n_vec++;
      if (cpu_gnt === 1'b1 && dbg_gnt === 1'b1) begin
        n_err++;
        $display("FAIL mutex t=%0t cpu_gnt=%b dbg_gnt=%b expected not both", $time, cpu_gnt, dbg_gnt);
      end
    end
  end

  task automatic test_reset();
    sync_rst = 1; clk_en = 0;
    drive_cpu(1, 0, 8'h10, 8'h00); drive_dbg(1, 0, 8'h11, 8'h00);
    #1;
    n_vec += 2;
    if (cpu_gnt !== 1'b0) begin n_err++; $display("FAIL rst_cpu_gnt got %b exp 0", cpu_gnt); end
    if (dbg_gnt !== 1'b0) begin n_err++; $display("FAIL rst_dbg_gnt got %b exp 0", dbg_gnt); end
    tick();
    clk_en = 1;
    tick();
    n_vec += 5;
    if (disp !== 8'h00) begin n_err++; $display("FAIL rst_disp got %h exp 00", disp); end
    if (cpu_rvalid !== 1'b0) begin n_err++; $display("FAIL rst_cpu_rvalid got %b exp 0", cpu_rvalid); end
    if (dbg_rvalid !== 1'b0) begin n_err++; $display("FAIL rst_dbg_rvalid got %b exp 0", dbg_rvalid); end
    if (cpu_rdata !== 8'h00) begin n_err++; $display("FAIL rst_cpu_rdata got %h exp 00", cpu_rdata); end
    if (dbg_rdata !== 8'h00) begin n_err++; $display("FAIL rst_dbg_rdata got %h exp 00", dbg_rdata); end
    sync_rst = 0;
    drive_cpu(0, 0, 0, 0); drive_dbg(0, 0, 0, 0);
  endtask

  task automatic test_cpu_rw();
    drive_cpu(1, 1, 8'h10, 8'h5A);
    #1;
    n_vec++;
    if (cpu_gnt !== 1'b1) begin n_err++; $display("FAIL rw_wr_gnt got %b exp 1", cpu_gnt); end
    tick();
    n_vec++;
    if (cpu_rvalid !== 1'b0) begin n_err++; $display("FAIL rw_wr_rvalid got %b exp 0", cpu_rvalid); end
    drive_cpu(1, 0, 8'h10, 8'h00);
    tick();
    n_vec += 3;
    if (cpu_rvalid !== 1'b1) begin n_err++; $display("FAIL rw_rvalid got %b exp 1", cpu_rvalid); end
    if (cpu_rdata !== 8'h5A) begin n_err++; $display("FAIL rw_rdata got %h exp 5a", cpu_rdata); end
    if (dbg_rvalid !== 1'b0) begin n_err++; $display("FAIL rw_dbg_rvalid got %b exp 0", dbg_rvalid); end
    drive_cpu(0, 0, 0, 0);
    tick();
    n_vec += 2;
    if (cpu_rvalid !== 1'b0) begin n_err++; $display("FAIL rw_pulse got %b exp 0", cpu_rvalid); end
    if (cpu_rdata !== 8'h5A) begin n_err++; $display("FAIL rw_hold got %h exp 5a", cpu_rdata); end
  endtask

  task automatic test_io();
    switches = 8'hC3;
    drive_cpu(1, 0, IO, 8'h00);
    tick();
    n_vec++;
    if (cpu_rdata !== 8'hC3) begin n_err++; $display("FAIL io_switch got %h exp c3", cpu_rdata); end
    drive_cpu(0, 0, 0, 0); drive_dbg(1, 1, IO, 8'h7E);
    #1;
    n_vec++;
    if (dbg_gnt !== 1'b1) begin n_err++; $display("FAIL io_dbg_gnt got %b exp 1", dbg_gnt); end
    tick();
    n_vec += 2;
    if (disp !== 8'h7E) begin n_err++; $display("FAIL io_disp got %h exp 7e", disp); end
    if (dbg_rvalid !== 1'b0) begin n_err++; $display("FAIL io_wr_rvalid got %b exp 0", dbg_rvalid); end
    drive_dbg(0, 0, 0, 0); drive_cpu(1, 0, 8'h10, 8'h00);
    tick();
    n_vec++;
    if (cpu_rdata !== 8'h5A) begin n_err++; $display("FAIL io_ram_intact got %h exp 5a", cpu_rdata); end
  endtask

  task automatic test_priority();
    drive_cpu(1, 0, 8'h10, 8'h00); drive_dbg(1, 0, 8'h11, 8'h00);
    for (int i = 0; i < 10; i++) begin
      #1;
      n_vec += 3;
      if (dbg_gnt !== (i % 5 == 4)) begin n_err++; $display("FAIL prio_dbg_gnt cyc %0d got %b exp %b", i, dbg_gnt, i % 5 == 4); end
      if (cpu_gnt !== (i % 5 != 4)) begin n_err++; $display("FAIL prio_cpu_gnt cyc %0d got %b exp %b", i, cpu_gnt, i % 5 != 4); end
      if (cpu_stall !== (i % 5 == 4)) begin n_err++; $display("FAIL prio_stall cyc %0d got %b exp %b", i, cpu_stall, i % 5 == 4); end
      tick();
      n_vec++;
      if (dbg_rvalid !== (i % 5 == 4)) begin n_err++; $display("FAIL prio_dbg_rvalid cyc %0d got %b exp %b", i, dbg_rvalid, i % 5 == 4); end
    end
    drive_dbg(0, 0, 0, 0);
  endtask

  task automatic test_clk_en();
    drive_cpu(1, 1, 8'h20, 8'h99);
    tick();
    clk_en = 0; drive_cpu(1, 0, 8'h20, 8'h00);
    #1;
    n_vec += 2;
    if (cpu_gnt !== 1'b0) begin n_err++; $display("FAIL en_gnt_off got %b exp 0", cpu_gnt); end
    if (cpu_stall !== 1'b1) begin n_err++; $display("FAIL en_stall_off got %b exp 1", cpu_stall); end
    tick();
    n_vec++;
    if (cpu_rvalid !== 1'b0) begin n_err++; $display("FAIL en_rvalid_off got %b exp 0", cpu_rvalid); end
    clk_en = 1;
    #1;
    n_vec++;
    if (cpu_gnt !== 1'b1) begin n_err++; $display("FAIL en_gnt_on got %b exp 1", cpu_gnt); end
    tick();
    n_vec += 2;
    if (cpu_rvalid !== 1'b1) begin n_err++; $display("FAIL en_rvalid got %b exp 1", cpu_rvalid); end
    if (cpu_rdata !== 8'h99) begin n_err++; $display("FAIL en_rdata got %h exp 99", cpu_rdata); end
    clk_en = 0; drive_cpu(0, 0, 0, 0);
    tick();
    n_vec++;
    if (cpu_rvalid !== 1'b1) begin n_err++; $display("FAIL en_rvalid_hold got %b exp 1", cpu_rvalid); end
    clk_en = 1;
    tick();
    n_vec++;
    if (cpu_rvalid !== 1'b0) begin n_err++; $display("FAIL en_rvalid_drop got %b exp 0", cpu_rvalid); end
  endtask

  task automatic test_reset_midflight();
    drive_dbg(1, 1, 8'h40, 8'h33);
    tick();
    drive_cpu(1, 0, 8'h10, 8'h00); drive_dbg(1, 0, 8'h40, 8'h00);
    for (int i = 0; i < 5; i++) begin
      #1;
      n_vec++;
      if (dbg_gnt !== (i == 4)) begin n_err++; $display("FAIL mid_pre_gnt cyc %0d got %b exp %b", i, dbg_gnt, i == 4); end
      tick();
    end
    n_vec += 2;
    if (dbg_rvalid !== 1'b1) begin n_err++; $display("FAIL mid_rvalid got %b exp 1", dbg_rvalid); end
    if (dbg_rdata !== 8'h33) begin n_err++; $display("FAIL mid_rdata got %h exp 33", dbg_rdata); end
    sync_rst = 1;
    #1;
    n_vec++;
    if (cpu_gnt !== 1'b0 || dbg_gnt !== 1'b0) begin n_err++; $display("FAIL mid_rst_gnt got %b%b exp 00", cpu_gnt, dbg_gnt); end
    tick();
    sync_rst = 0;
    n_vec += 3;
    if (dbg_rvalid !== 1'b0) begin n_err++; $display("FAIL mid_rst_rvalid got %b exp 0", dbg_rvalid); end
    if (disp !== 8'h00) begin n_err++; $display("FAIL mid_rst_disp got %h exp 00", disp); end
    if (dbg_rdata !== 8'h00) begin n_err++; $display("FAIL mid_rst_rdata got %h exp 00", dbg_rdata); end
    for (int i = 0; i < 5; i++) begin
      #1;
      n_vec++;
      if (dbg_gnt !== (i == 4)) begin n_err++; $display("FAIL mid_wait_cleared cyc %0d got %b exp %b", i, dbg_gnt, i == 4); end
      tick();
    end
    drive_dbg(0, 0, 0, 0); drive_cpu(1, 0, 8'h40, 8'h00);
    tick();
    n_vec++;
    if (cpu_rdata !== 8'h33) begin n_err++; $display("FAIL mid_ram_intact got %h exp 33", cpu_rdata); end
    drive_cpu(0, 0, 0, 0);
  endtask

  task automatic test_back_to_back();
    logic [7:0] d [4];
    for (int i = 0; i < 4; i++) begin
      d[i] = 8'($urandom);
      drive_cpu(1, 1, 8'h50 + 8'(i), d[i]);
      tick();
      drive_cpu(1, 0, 8'h50 + 8'(i), 8'h00);
      tick();
      n_vec++;
      if (cpu_rdata !== d[i]) begin n_err++; $display("FAIL b2b_raw %0d got %h exp %h", i, cpu_rdata, d[i]); end
    end
    drive_cpu(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      drive_dbg(1, 0, 8'h50 + 8'(i), 8'h00);
      tick();
      n_vec += 2;
      if (dbg_rvalid !== 1'b1) begin n_err++; $display("FAIL b2b_rvalid %0d got %b exp 1", i, dbg_rvalid); end
      if (dbg_rdata !== d[i]) begin n_err++; $display("FAIL b2b_rdata %0d got %h exp %h", i, dbg_rdata, d[i]); end
    end
    drive_dbg(0, 0, 0, 0);
  endtask

  task automatic test_random();
    int starve = 0;
    for (int n = 0; n < 600; n++) begin
      sync_rst = ($urandom_range(0, 63) == 0);
      clk_en   = ($urandom_range(0, 4) != 0);
      switches = 8'($urandom);
      drive_cpu($urandom_range(0, 9) < 6, 1'($urandom), 8'h60 + 8'($urandom_range(0, 7)), 8'($urandom));
      if ($urandom_range(0, 7) == 0) cpu_addr = IO;
      if (dbg_req) dbg_req = ($urandom_range(0, 7) != 0);
      else dbg_req = 1'($urandom);
      dbg_we = 1'($urandom); dbg_wdata = 8'($urandom);
      dbg_addr = ($urandom_range(0, 7) == 0) ? IO : 8'h60 + 8'($urandom_range(0, 7));
      #1;
      predict();
      n_vec += 3;
      if (cpu_gnt !== e_cg) begin n_err++; $display("FAIL rnd_cpu_gnt n=%0d got %b exp %b", n, cpu_gnt, e_cg); end
      if (dbg_gnt !== e_dg) begin n_err++; $display("FAIL rnd_dbg_gnt n=%0d got %b exp %b", n, dbg_gnt, e_dg); end
      if (cpu_stall !== (cpu_req && !e_cg)) begin n_err++; $display("FAIL rnd_stall n=%0d got %b exp %b", n, cpu_stall, cpu_req && !e_cg); end
      if (!dbg_req || sync_rst || dbg_gnt) starve = 0;
      else if (clk_en) starve++;
      n_vec++;
      if (starve > MAXW) begin n_err++; $display("FAIL rnd_starve n=%0d got %0d exp <=%0d", n, starve, MAXW); end
      tick();
      n_vec += 3;
      if (cpu_rvalid !== m_crv) begin n_err++; $display("FAIL rnd_cpu_rvalid n=%0d got %b exp %b", n, cpu_rvalid, m_crv); end
      if (dbg_rvalid !== m_drv) begin n_err++; $display("FAIL rnd_dbg_rvalid n=%0d got %b exp %b", n, dbg_rvalid, m_drv); end
      if (disp !== m_disp) begin n_err++; $display("FAIL rnd_disp n=%0d got %h exp %h", n, disp, m_disp); end
      if (m_crd_k) begin
        n_vec++;
        if (cpu_rdata !== m_crd) begin n_err++; $display("FAIL rnd_cpu_rdata n=%0d got %h exp %h", n, cpu_rdata, m_crd); end
      end
      if (m_drd_k) begin
        n_vec++;
        if (dbg_rdata !== m_drd) begin n_err++; $display("FAIL rnd_dbg_rdata n=%0d got %h exp %h", n, dbg_rdata, m_drd); end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin m_ram[i] = 8'h00; m_known[i] = 1'b0; end
    m_disp = 0; m_crd = 0; m_drd = 0; m_crv = 0; m_drv = 0;
    m_crd_k = 1; m_drd_k = 1; m_denied = 0;
    sync_rst = 1; clk_en = 0; switches = 0;
    drive_cpu(0, 0, 0, 0); drive_dbg(0, 0, 0, 0);
    test_reset();
    test_cpu_rw();
    test_io();
    test_priority();
    test_clk_en();
    test_reset_midflight();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
